// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI controller datapath
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-order encodings shared with the SPI controller FSM
    localparam bit BIT_ORDER_MSB = 1'b1;
    localparam bit BIT_ORDER_LSB = 1'b0;

    // Counter width able to hold the values 0..width
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - full-duplex parametrised SPI shift engine with strobed shifting
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = BIT_ORDER_MSB,
    localparam int CNT_W    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             ena,
    input  logic             abort,
    input  logic             sdi,
    output logic             sdo,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   tx_q, tx_nxt, tx_adv;
    logic [WIDTH-1:0]   rx_q, rx_nxt, rx_adv;
    logic [WIDTH-1:0]   rx_data_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               done_nxt;
    logic               tx_bit;

    generate
        if (MSB_FIRST == BIT_ORDER_MSB) begin : g_msb
            assign tx_bit = tx_q[WIDTH-1];
            assign tx_adv = {tx_q[WIDTH-2:0], 1'b0};
            assign rx_adv = {rx_q[WIDTH-2:0], sdi};
        end else begin : g_lsb
            assign tx_bit = tx_q[0];
            assign tx_adv = {1'b0, tx_q[WIDTH-1:1]};
            assign rx_adv = {sdi, rx_q[WIDTH-1:1]};
        end
    endgenerate

    // The head of the tx register is the line bit; it is forced low outside a transfer
    assign sdo  = (state == SHIFT) && tx_bit;
    assign busy = (state == SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rx_data <= '0;
            done    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tx_q    <= tx_nxt;
            rx_q    <= rx_nxt;
            rx_data <= rx_data_nxt;
            done    <= done_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx_q;
        rx_nxt      = rx_q;
        rx_data_nxt = rx_data;
        cnt_nxt     = bit_cnt;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    tx_nxt    = tx_data;
                    rx_nxt    = '0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (ena) begin
                    tx_nxt  = tx_adv;
                    rx_nxt  = rx_adv;
                    cnt_nxt = bit_cnt + CNT_W'(1);
                    // Final strobe: publish the word including the bit sampled now
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        rx_data_nxt = rx_adv;
                        done_nxt    = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - self-checking bench for spi_shift_engine over four builds
module tb_spi_shift_engine;

    function automatic int ws(input int i);
        case (i)
            0:       return 8;
            1:       return 8;
            2:       return 16;
            default: return 2;
        endcase
    endfunction

    function automatic bit ms(input int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        load_v[4], ena_v[4], abort_v[4], sdi_v[4], loop_v[4];
    logic [31:0] txd_v[4];
    logic        sdo_w[4], busy_w[4], done_w[4], sdi_w[4];
    logic [31:0] rx_w[4];
    logic [7:0]  bc_w[4];

    int checks = 0;
    int failures = 0;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            localparam int W  = ws(g);
            localparam int CW = $clog2(W + 1);
            logic [W-1:0]  rxd;
            logic [CW-1:0] bc;
            assign sdi_w[g] = loop_v[g] ? sdo_w[g] : sdi_v[g];
            spi_shift_engine #(.WIDTH(W), .MSB_FIRST(ms(g))) u_dut (
                .clk     (clk),
                .rst     (rst_n),
                .load    (load_v[g]),
                .tx_data (txd_v[g][W-1:0]),
                .ena     (ena_v[g]),
                .abort   (abort_v[g]),
                .sdi     (sdi_w[g]),
                .sdo     (sdo_w[g]),
                .rx_data (rxd),
                .busy    (busy_w[g]),
                .done    (done_w[g]),
                .bit_cnt (bc)
            );
            assign rx_w[g] = 32'(rxd);
            assign bc_w[g] = 8'(bc);
        end
    endgenerate

    // Transaction-level model: a word, a count of bits sent, and the list of sampled bits
    bit          m_busy[4], m_done[4];
    logic [31:0] m_word[4], m_smp[4], m_rx[4];
    int          m_k[4];

    function automatic logic m_sdo(input int i);
        if (!m_busy[i]) return 1'b0;
        return m_word[i][ms(i) ? ws(i) - 1 - m_k[i] : m_k[i]];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                m_busy[i] = 1'b0; m_done[i] = 1'b0; m_word[i] = '0;
                m_smp[i]  = '0;   m_rx[i]   = '0;   m_k[i]    = 0;
            end else begin
                logic s;
                s = loop_v[i] ? m_sdo(i) : sdi_v[i];
                m_done[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (load_v[i]) begin
                        m_busy[i] = 1'b1; m_word[i] = txd_v[i]; m_k[i] = 0; m_smp[i] = '0;
                    end
                end else if (abort_v[i]) begin
                    m_busy[i] = 1'b0;
                end else if (ena_v[i]) begin
                    m_smp[i][m_k[i]] = s;
                    m_k[i]++;
                    if (m_k[i] == ws(i)) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_rx[i]   = '0;
                        for (int j = 0; j < ws(i); j++)
                            m_rx[i][ms(i) ? ws(i) - 1 - j : j] = m_smp[i][j];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d_sdo", i),  32'(sdo_w[i]),  32'(m_sdo(i)));
            chk($sformatf("u%0d_busy", i), 32'(busy_w[i]), 32'(m_busy[i]));
            chk($sformatf("u%0d_done", i), 32'(done_w[i]), 32'(m_done[i]));
            chk($sformatf("u%0d_rx", i),   rx_w[i],        m_rx[i]);
            chk($sformatf("u%0d_cnt", i),  32'(bc_w[i]),   32'(m_k[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer; ml>0 pulses a stray load of 0x55 after that edge, ab raises abort with load
    task automatic xfer(input int i, input logic [31:0] w, input bit lp, input bit sv,
                        input int gap, input int ml, input bit ab,
                        output logic [31:0] seq, output int edges);
        logic pe;
        seq = '0;
        edges = 0;
        loop_v[i] = lp; sdi_v[i] = sv; abort_v[i] = ab;
        load_v[i] = 1'b1; txd_v[i] = w; ena_v[i] = 1'b1;
        while (edges < 400) begin
            pe = ena_v[i];
            tick();
            edges++;
            load_v[i]  = (edges == ml);
            if (edges == ml) txd_v[i] = 32'h55;
            abort_v[i] = 1'b0;
            ena_v[i]   = (edges % gap == 0);
            if (done_w[i]) break;
            if (busy_w[i] && (edges == 1 || pe)) seq = {seq[30:0], sdo_w[i]};
        end
        ena_v[i] = 1'b0;
        loop_v[i] = 1'b0;
        chk("xfer_done_reached", 32'(done_w[i]), 32'd1);
    endtask

    logic [31:0] seq;
    int          e;

    initial begin
        for (int i = 0; i < 4; i++) begin
            load_v[i] = 0; ena_v[i] = 0; abort_v[i] = 0; sdi_v[i] = 0; loop_v[i] = 0; txd_v[i] = '0;
        end
        rst_n = 1'b0;
        tick();
        chk("rst_sdo",  32'(sdo_w[0]),  32'd0);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_rx",   rx_w[0],        32'd0);
        chk("rst_cnt",  32'(bc_w[0]),   32'd0);
        rst_n = 1'b1;
        tick();

        // MSB-first loopback of 0xA5 with ena held high
        xfer(0, 32'hA5, 1, 0, 1, 0, 0, seq, e);
        chk("t1_seq",   seq[7:0],       32'hA5);
        chk("t1_edges", 32'(e),         32'd9);
        chk("t1_rx",    rx_w[0],        32'hA5);
        chk("t1_cnt",   32'(bc_w[0]),   32'd8);
        chk("t1_busy",  32'(busy_w[0]), 32'd0);

        // ena alone in IDLE is ignored
        ena_v[0] = 1'b1;
        repeat (3) tick();
        ena_v[0] = 1'b0;
        chk("idle_ena_cnt", 32'(bc_w[0]), 32'd8);
        chk("idle_ena_rx",  rx_w[0],      32'hA5);

        // LSB-first 0x01 with sdi tied high, strobe every third cycle
        xfer(1, 32'h01, 0, 1, 3, 0, 0, seq, e);
        chk("t2_seq",   seq[7:0],     32'h80);
        chk("t2_edges", 32'(e),       32'd25);
        chk("t2_rx",    rx_w[1],      32'hFF);
        chk("t2_cnt",   32'(bc_w[1]), 32'd8);

        // Abort after three strobes keeps the previous word
        xfer(0, 32'h3C, 1, 0, 1, 0, 0, seq, e);
        chk("t3_prior_rx", rx_w[0], 32'h3C);
        tick();
        load_v[0] = 1'b1; txd_v[0] = 32'h99; ena_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        repeat (3) tick();
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0; ena_v[0] = 1'b0;
        chk("t3_busy", 32'(busy_w[0]), 32'd0);
        chk("t3_sdo",  32'(sdo_w[0]),  32'd0);
        chk("t3_cnt",  32'(bc_w[0]),   32'd3);
        chk("t3_rx",   rx_w[0],        32'h3C);
        chk("t3_done", 32'(done_w[0]), 32'd0);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        chk("t3_idle_abort_busy", 32'(busy_w[0]), 32'd0);
        tick();

        // Stray load mid-transfer, then a back-to-back load in the done cycle
        xfer(0, 32'hF0, 1, 0, 2, 4, 0, seq, e);
        chk("t4_seq", seq[7:0], 32'hF0);
        chk("t4_rx",  rx_w[0],  32'hF0);
        xfer(0, 32'h81, 1, 0, 1, 0, 0, seq, e);
        chk("t4_b2b_edges", 32'(e),   32'd9);
        chk("t4_b2b_seq",   seq[7:0], 32'h81);
        chk("t4_b2b_rx",    rx_w[0],  32'h81);
        tick();

        // Asynchronous reset after four strobes
        loop_v[0] = 1'b1; load_v[0] = 1'b1; txd_v[0] = 32'hC3; ena_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        repeat (4) tick();
        chk("t5_pre_cnt", 32'(bc_w[0]), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_sdo",  32'(sdo_w[0]),  32'd0);
        chk("t5_busy", 32'(busy_w[0]), 32'd0);
        chk("t5_done", 32'(done_w[0]), 32'd0);
        chk("t5_cnt",  32'(bc_w[0]),   32'd0);
        chk("t5_rx",   rx_w[0],        32'd0);
        ena_v[0] = 1'b0; loop_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        xfer(0, 32'h81, 1, 0, 1, 0, 1, seq, e);
        chk("t5_after_seq", seq[7:0], 32'h81);
        chk("t5_after_rx",  rx_w[0],  32'h81);

        // Wide and narrow builds
        xfer(2, 32'hBEEF, 1, 0, 1, 0, 0, seq, e);
        chk("t6_w16_seq",   seq[15:0],    32'hBEEF);
        chk("t6_w16_rx",    rx_w[2],      32'hBEEF);
        chk("t6_w16_cnt",   32'(bc_w[2]), 32'd16);
        chk("t6_w16_edges", 32'(e),       32'd17);
        xfer(3, 32'h2, 1, 0, 1, 0, 0, seq, e);
        chk("t6_w2_seq",   seq[1:0],     32'h2);
        chk("t6_w2_rx",    rx_w[3],      32'h2);
        chk("t6_w2_cnt",   32'(bc_w[3]), 32'd2);
        chk("t6_w2_edges", 32'(e),       32'd3);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
